// File: rtl/fir_tap_line.sv
// fir_tap_line: serial sample feeder for a combinational FIR mac stage.
// Shifts accepted samples into a NUM_REGS-deep tap line, keeps a
// double-buffered coefficient bank and pulses tapsValid on every cycle
// in which the taps and active coefficients form a complete window.
module fir_tap_line #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [DATA_WIDTH-1:0]          sampleIn,
  input  logic                                  sampleValid,
  output logic                                  sampleReady,
  input  logic                                  flush,
  input  logic                                  coefWrEn,
  input  logic [$clog2(NUM_REGS)-1:0]           coefAddr,
  input  logic signed [DATA_WIDTH-1:0]          coefWrData,
  input  logic                                  coefCommit,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   pDataOut,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   coefsOut,
  output logic                                  tapsValid,
  output logic [$clog2(NUM_REGS+1)-1:0]         fillCount
);

  localparam int CW = $clog2(NUM_REGS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_REGS);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                                state_q, state_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   taps_q, taps_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   shadow_q, shadow_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   coef_q, coef_d;
  logic [CW-1:0]                         fill_q, fill_d;
  logic                                  taps_valid_q, taps_valid_d;
  logic                                  accept;

  // Handshake: no accepts during reset, the flush cycle, or a flush request.
  assign sampleReady = !rst && (state_q != S_FLUSH) && !flush;
  assign accept      = sampleValid && sampleReady;

  // Next state for the tap line, fill counter, FSM and coefficient banks.
  always_comb begin
    state_d      = state_q;
    taps_d       = taps_q;
    fill_d       = fill_q;
    taps_valid_d = 1'b0;
    shadow_d     = shadow_q;
    coef_d       = coef_q;

    case (state_q)
      S_FLUSH: begin
        state_d = S_FILL;
      end
      default: begin
        if (flush) begin
          // Flush wins over a same-cycle sample; coefficients stay as they are.
          taps_d  = '0;
          fill_d  = '0;
          state_d = S_FLUSH;
        end else if (accept) begin
          taps_d = {taps_q[NUM_REGS-2:0], sampleIn};
          if (fill_q != FULL) begin
            fill_d = fill_q + CW'(1);
          end
          if (fill_d == FULL) begin
            state_d      = S_RUN;
            taps_valid_d = 1'b1;
          end
        end
      end
    endcase

    // Shadow write happens first so a same-cycle commit picks up the new word.
    if (coefWrEn && (int'(coefAddr) < NUM_REGS)) begin
      shadow_d[coefAddr] = coefWrData;
    end
    if (coefCommit) begin
      coef_d = shadow_d;
    end
  end

  // State registers; reset clears taps, both coefficient banks and control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FILL;
      taps_q       <= '0;
      shadow_q     <= '0;
      coef_q       <= '0;
      fill_q       <= '0;
      taps_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      taps_q       <= taps_d;
      shadow_q     <= shadow_d;
      coef_q       <= coef_d;
      fill_q       <= fill_d;
      taps_valid_q <= taps_valid_d;
    end
  end

  assign pDataOut  = taps_q;
  assign coefsOut  = coef_q;
  assign tapsValid = taps_valid_q;
  assign fillCount = fill_q;

endmodule
